// File: rtl/fe_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode
// valid/ready handshake. The fetch controller is the master on both.
interface fe_fetch_ctrl_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_rdata;
    logic            imem_ack;
    logic [23:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_rdata,
        input  imem_ack,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_rdata,
        output imem_ack,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fe_fetch_ctrl.sv
// Fetch sequencer for the 8-bit RISC pipeline. Owns the PC, reads two
// 16-bit words per 24-bit instruction (word @pc -> instr[15:0], low byte of
// word @pc+1 -> instr[23:16]) and hands the result to decode over a
// valid/ready handshake, with stall and branch-redirect handling.
// Optional feature: define FE_STALL_CNT_EN to add a saturating stall
// counter (ports stall_cnt, cnt_clr).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | fetch stopped, no read outstanding
// LO    | reading word @pc (instr[15:0])
// HI    | reading word @pc+1 (instr[23:16])
// OUT   | instruction presented to decode, waiting for instr_ready
// DRAIN | redirect arrived mid-read; waiting out the old read's ack
module fe_fetch_ctrl #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            busy,
`ifdef FE_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
    input  logic            cnt_clr,
`endif
    fe_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        OUT   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc1;
    logic [PC_W-1:0] pc_inc2;
    logic            transfer;

    assign pc_inc1  = pc + PC_W'(1);
    assign pc_inc2  = pc + PC_W'(2);
    assign transfer = bus.instr_valid & bus.instr_ready;

    // Fetch FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            bus.imem_addr   <= RESET_PC;
            bus.imem_rd     <= 1'b0;
            bus.instr       <= '0;
            bus.instr_pc    <= RESET_PC;
            bus.instr_valid <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_taken) begin
                        pc            <= br_target;
                        bus.imem_addr <= br_target;
                    end else if (run) begin
                        state         <= LO;
                        bus.imem_rd   <= 1'b1;
                        bus.imem_addr <= pc;
                        busy          <= 1'b1;
                    end
                end

                LO, HI: begin
                    if (br_taken) begin
                        pc <= br_target;
                        if (bus.imem_ack) begin
                            // Old read just completed: drop its data and
                            // start on the target right away.
                            state         <= LO;
                            bus.imem_addr <= br_target;
                        end else begin
                            // Keep the address steady until the old ack.
                            state <= DRAIN;
                        end
                    end else if (bus.imem_ack) begin
                        if (state == LO) begin
                            bus.instr[15:0] <= bus.imem_rdata;
                            bus.imem_addr   <= pc_inc1;
                            state           <= HI;
                        end else begin
                            bus.instr[23:16] <= bus.imem_rdata[7:0];
                            bus.imem_rd      <= 1'b0;
                            bus.instr_valid  <= 1'b1;
                            bus.instr_pc     <= pc;
                            state            <= OUT;
                        end
                    end
                end

                OUT: begin
                    if (br_taken) begin
                        // A coincident transfer still completes; the target
                        // simply replaces pc+2.
                        pc              <= br_target;
                        bus.instr_valid <= 1'b0;
                        bus.imem_rd     <= 1'b1;
                        bus.imem_addr   <= br_target;
                        state           <= LO;
                    end else if (transfer) begin
                        pc              <= pc_inc2;
                        bus.instr_valid <= 1'b0;
                        bus.imem_addr   <= pc_inc2;
                        if (run) begin
                            bus.imem_rd <= 1'b1;
                            state       <= LO;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end

                DRAIN: begin
                    if (bus.imem_ack) begin
                        // Stale data is dropped; a redirect landing on the
                        // same cycle as the ack still wins the new pc.
                        state         <= LO;
                        pc            <= br_taken ? br_target : pc;
                        bus.imem_addr <= br_taken ? br_target : pc;
                    end else if (br_taken) begin
                        pc <= br_target;
                    end
                end

                default: begin
                    state           <= IDLE;
                    bus.imem_rd     <= 1'b0;
                    bus.instr_valid <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

`ifdef FE_STALL_CNT_EN
    logic stall_evt;

    assign stall_evt = (bus.instr_valid & ~bus.instr_ready) |
                       (bus.imem_rd & ~bus.imem_ack);

    // Saturating count of cycles lost to decode back-pressure or memory wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed bench for fe_fetch_ctrl: one instance at RESET_PC=00 for the main
// sequence, one at RESET_PC=FE for the address-wrap case.
module tb_fe_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       run, br_taken, busy;
    logic [7:0] br_target;
    logic       run_f, br_taken_f, busy_f;
    logic [7:0] br_target_f;
`ifdef FE_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt_f;
    logic        cnt_clr;
`endif

    fe_fetch_ctrl_if #(.PC_W(8)) m_if ();
    fe_fetch_ctrl_if #(.PC_W(8)) f_if ();

    fe_fetch_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .br_taken  (br_taken),
        .br_target (br_target),
        .busy      (busy),
`ifdef FE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
        .cnt_clr   (cnt_clr),
`endif
        .bus       (m_if)
    );

    fe_fetch_ctrl #(.PC_W(8), .RESET_PC(8'hFE)) dut_fe (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run_f),
        .br_taken  (br_taken_f),
        .br_target (br_target_f),
        .busy      (busy_f),
`ifdef FE_STALL_CNT_EN
        .stall_cnt (stall_cnt_f),
        .cnt_clr   (cnt_clr),
`endif
        .bus       (f_if)
    );

    logic [15:0] mem [256];
    int          lat_m = 1;
    int          wait_m = 0;
    int          wait_f = 0;
    int          xfer_m = 0;
    logic [7:0]  log_m [$];
    logic [7:0]  log_f [$];
    int          checks = 0;
    int          failures = 0;

    // Memory responders: ack after lat_m un-acked request cycles.
    always @(negedge clk) begin
        m_if.imem_ack = 1'b0;
        if (!rst_n || !m_if.imem_rd) begin
            wait_m = 0;
        end else if (wait_m >= lat_m) begin
            m_if.imem_ack   = 1'b1;
            m_if.imem_rdata = mem[m_if.imem_addr];
            log_m.push_back(m_if.imem_addr);
            wait_m = 0;
        end else begin
            wait_m++;
        end
    end

    always @(negedge clk) begin
        f_if.imem_ack = 1'b0;
        if (!rst_n || !f_if.imem_rd) begin
            wait_f = 0;
        end else if (wait_f >= 1) begin
            f_if.imem_ack   = 1'b1;
            f_if.imem_rdata = mem[f_if.imem_addr];
            log_f.push_back(f_if.imem_addr);
            wait_f = 0;
        end else begin
            wait_f++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && m_if.instr_valid && m_if.instr_ready) xfer_m++;
    end

    function automatic logic [23:0] exp_instr(input logic [7:0] p);
        logic [7:0] q;
        q = p + 8'd1;
        return {q, ~p, p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_m_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_if.instr_valid && n < 60);
        chk(tag, 32'(m_if.instr_valid), 32'd1);
    endtask

    task automatic wait_f_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!f_if.instr_valid && n < 60);
        chk(tag, 32'(f_if.instr_valid), 32'd1);
    endtask

    task automatic wait_m_addr_change(input string tag, input logic [7:0] from);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_if.imem_addr == from && n < 60);
        chk(tag, 32'(m_if.imem_addr != from), 32'd1);
    endtask

    initial begin
        int x0;
        logic [23:0] held;

        for (int i = 0; i < 256; i++) mem[i] = {~8'(i), 8'(i)};
        mem[0] = 16'hAB12;
        mem[1] = 16'h00CD;

        rst_n = 1'b0;
        run = 1'b0; br_taken = 1'b0; br_target = 8'h00;
        run_f = 1'b0; br_taken_f = 1'b0; br_target_f = 8'h00;
        m_if.imem_ack = 1'b0; m_if.imem_rdata = 16'h0; m_if.instr_ready = 1'b1;
        f_if.imem_ack = 1'b0; f_if.imem_rdata = 16'h0; f_if.instr_ready = 1'b1;
`ifdef FE_STALL_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);

        chk("rst_instr", 32'(m_if.instr), 32'h0);
        chk("rst_valid", 32'(m_if.instr_valid), 32'd0);
        chk("rst_rd", 32'(m_if.imem_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(m_if.imem_addr), 32'h00);
        chk("rst_ipc", 32'(m_if.instr_pc), 32'h00);
        chk("rst_fe_addr", 32'(f_if.imem_addr), 32'hFE);
        chk("rst_fe_ipc", 32'(f_if.instr_pc), 32'hFE);

        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rd", 32'(m_if.imem_rd), 32'd0);

        // Basic fetch
        run = 1'b1;
        @(negedge clk);
        chk("t1_rd", 32'(m_if.imem_rd), 32'd1);
        chk("t1_addr", 32'(m_if.imem_addr), 32'h00);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_m_valid("t1_valid");
        chk("t1_instr", 32'(m_if.instr), 32'hCDAB12);
        chk("t1_ipc", 32'(m_if.instr_pc), 32'h00);
        @(negedge clk);
        chk("t1_next_addr", 32'(m_if.imem_addr), 32'h02);
        chk("t1_next_rd", 32'(m_if.imem_rd), 32'd1);
        chk("t1_valid_drop", 32'(m_if.instr_valid), 32'd0);

        // Decode stall for 5 cycles
        m_if.instr_ready = 1'b0;
        wait_m_valid("t2_valid");
        held = m_if.instr;
        chk("t2_instr", 32'(held), 32'h03FD02);
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_instr", 32'(m_if.instr), 32'(held));
            chk("t2_hold_ipc", 32'(m_if.instr_pc), 32'h02);
            chk("t2_hold_valid", 32'(m_if.instr_valid), 32'd1);
            chk("t2_hold_rd", 32'(m_if.imem_rd), 32'd0);
            @(negedge clk);
        end
        m_if.instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_next_addr", 32'(m_if.imem_addr), 32'h04);
        chk("t2_next_rd", 32'(m_if.imem_rd), 32'd1);

        // Redirect during HI with slow ack
        lat_m = 3;
        wait_m_addr_change("t3_to_hi", 8'h04);
        chk("t3_hi_addr", 32'(m_if.imem_addr), 32'h05);
        br_taken = 1'b1; br_target = 8'h40;
        @(negedge clk);
        br_taken = 1'b0;
        chk("t3_drain_addr0", 32'(m_if.imem_addr), 32'h05);
        chk("t3_drain_rd", 32'(m_if.imem_rd), 32'd1);
        @(negedge clk);
        chk("t3_drain_addr1", 32'(m_if.imem_addr), 32'h05);
        wait_m_addr_change("t3_leave_drain", 8'h05);
        chk("t3_new_addr", 32'(m_if.imem_addr), 32'h40);
        chk("t3_new_rd", 32'(m_if.imem_rd), 32'd1);
        chk("t3_old_acked", 32'(log_m[log_m.size()-1]), 32'h05);
        lat_m = 1;
        wait_m_valid("t3_valid");
        chk("t3_ipc", 32'(m_if.instr_pc), 32'h40);
        chk("t3_instr", 32'(m_if.instr), 32'(exp_instr(8'h40)));

        // Redirect in OUT with instr_ready=1
        wait_m_valid("t5_valid");
        chk("t5_ipc", 32'(m_if.instr_pc), 32'h42);
        x0 = xfer_m;
        br_taken = 1'b1; br_target = 8'h10;
        @(negedge clk);
        br_taken = 1'b0;
        chk("t5_xfer", 32'(xfer_m), 32'(x0 + 1));
        chk("t5_valid_drop", 32'(m_if.instr_valid), 32'd0);
        chk("t5_addr", 32'(m_if.imem_addr), 32'h10);
        wait_m_valid("t5_valid2");
        chk("t5_ipc2", 32'(m_if.instr_pc), 32'h10);
        chk("t5_instr2", 32'(m_if.instr), 32'(exp_instr(8'h10)));

        // run dropped mid-instruction: finishes, transfers, idles
        @(negedge clk);
        chk("run0_addr", 32'(m_if.imem_addr), 32'h12);
        run = 1'b0;
        wait_m_valid("run0_valid");
        chk("run0_ipc", 32'(m_if.instr_pc), 32'h12);
        chk("run0_instr", 32'(m_if.instr), 32'(exp_instr(8'h12)));
        @(negedge clk);
        chk("run0_busy", 32'(busy), 32'd0);
        chk("run0_rd", 32'(m_if.imem_rd), 32'd0);
        chk("run0_valid_drop", 32'(m_if.instr_valid), 32'd0);

        // Redirect while idle loads pc only
        br_taken = 1'b1; br_target = 8'h80;
        @(negedge clk);
        br_taken = 1'b0;
        chk("idle_br_busy", 32'(busy), 32'd0);
        chk("idle_br_rd", 32'(m_if.imem_rd), 32'd0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("idle_br_addr", 32'(m_if.imem_addr), 32'h80);
        chk("idle_br_rd2", 32'(m_if.imem_rd), 32'd1);
        wait_m_valid("idle_br_valid");
        chk("idle_br_ipc", 32'(m_if.instr_pc), 32'h80);
        @(negedge clk);
        chk("idle_br_done", 32'(busy), 32'd0);

        // RESET_PC=FE wraps through FF to 00
        run_f = 1'b1;
        wait_f_valid("t4_valid0");
        chk("t4_ipc0", 32'(f_if.instr_pc), 32'hFE);
        chk("t4_instr0", 32'(f_if.instr), 32'hFF01FE);
        @(negedge clk);
        wait_f_valid("t4_valid1");
        chk("t4_ipc1", 32'(f_if.instr_pc), 32'h00);
        chk("t4_instr1", 32'(f_if.instr), 32'hCDAB12);
        run_f = 1'b0;
        @(negedge clk);
        chk("t4_nreads", 32'(log_f.size()), 32'd4);
        if (log_f.size() >= 4) begin
            chk("t4_addr0", 32'(log_f[0]), 32'hFE);
            chk("t4_addr1", 32'(log_f[1]), 32'hFF);
            chk("t4_addr2", 32'(log_f[2]), 32'h00);
            chk("t4_addr3", 32'(log_f[3]), 32'h01);
        end

`ifdef FE_STALL_CNT_EN
        // 2 memory-wait cycles + 5 decode-stall cycles
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("t6_clr0", 32'(stall_cnt), 32'd0);
        m_if.instr_ready = 1'b0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        wait_m_valid("t6_valid");
        repeat (5) @(negedge clk);
        m_if.instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_cnt", 32'(stall_cnt), 32'd7);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("t6_clr1", 32'(stall_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
